// File: rtl/config_loader_pkg.sv
// Shared types and constants for the configuration-chain loader and its
// readback capture path.
package cfg_pkg;

    localparam int BYTE_W = 8;
    localparam int IDX_W  = $clog2(BYTE_W);

    // Holds 0..BYTE_W, so one bit wider than a bit index.
    typedef logic [IDX_W:0] bitcnt_t;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_BYTE,
        SHIFT,
        FINISH
    } state_e;

    // Bits still to shift for the next byte: a full byte, or the remainder of the chain.
    function automatic bitcnt_t bits_for_byte(input logic [31:0] remaining);
        if (remaining >= 32'(BYTE_W)) begin
            return bitcnt_t'(BYTE_W);
        end
        return bitcnt_t'(remaining);
    endfunction

endpackage

// File: rtl/config_loader_readback.sv
// Serial-to-byte capture of the bits returning from the chain tail, plus the
// single-entry r_valid/r_ready output slot.
module readback_assembler
    import cfg_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cap_en_i,
    input  logic [IDX_W-1:0]  cap_idx_i,
    input  logic              cap_bit_i,
    input  logic              commit_i,
    input  logic              r_ready_i,
    output logic [BYTE_W-1:0] r_data_o,
    output logic              r_valid_o,
    output logic              slot_free_o
);

    logic [BYTE_W-1:0] cap_q, cap_d, cap_upd;
    logic [BYTE_W-1:0] r_data_q, r_data_d;
    logic              r_valid_q, r_valid_d;

    always_comb begin
        cap_upd            = cap_q;
        cap_upd[cap_idx_i] = cap_bit_i;
        cap_d              = cap_q;
        r_data_d           = r_data_q;
        r_valid_d          = r_valid_q & ~r_ready_i;
        if (cap_en_i) begin
            cap_d = cap_upd;
        end
        // The final bit goes straight into the slot; clearing the capture register
        // keeps the unused high bits of a partial byte at zero.
        if (commit_i) begin
            r_data_d  = cap_upd;
            r_valid_d = 1'b1;
            cap_d     = '0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cap_q     <= '0;
            r_data_q  <= '0;
            r_valid_q <= 1'b0;
        end else begin
            cap_q     <= cap_d;
            r_data_q  <= r_data_d;
            r_valid_q <= r_valid_d;
        end
    end

    assign r_data_o    = r_data_q;
    assign r_valid_o   = r_valid_q;
    assign slot_free_o = ~r_valid_q | r_ready_i;

endmodule

// File: rtl/config_loader.sv
// Configuration-chain master: serialises bitstream bytes LSB first into the
// row chain for exactly CHAIN_LEN shifts while capturing the old contents as readback bytes.
module config_loader
    import cfg_pkg::*;
#(
    parameter int CHAIN_LEN = 4096
) (
    input  logic        prog_clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  s_data,
    input  logic        s_valid,
    output logic        s_ready,
    output logic        prog_en,
    output logic        prog_data,
    input  logic        prog_ret,
    output logic [7:0]  r_data,
    output logic        r_valid,
    input  logic        r_ready,
    output logic        busy,
    output logic        done
);

    localparam int CNT_W = $clog2(CHAIN_LEN + 1);

    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both 1; valid never waits on ready, and r_data holds while r_valid is unanswered.

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    bitcnt_t           k_q, k_d;
    bitcnt_t           nbits_q, nbits_d;
    bitcnt_t           k_next;
    logic [BYTE_W-1:0] byte_q, byte_d;
    logic              prog_en_q, prog_en_d;
    logic              prog_data_q, prog_data_d;
    logic              s_ready_q, s_ready_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              cap_en, commit, slot_free;
    logic [31:0]       rem;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        k_d         = k_q;
        nbits_d     = nbits_q;
        byte_d      = byte_q;
        prog_en_d   = 1'b0;
        prog_data_d = prog_data_q;
        busy_d      = busy_q;
        done_d      = done_q;
        cap_en      = 1'b0;
        commit      = 1'b0;
        k_next      = k_q + bitcnt_t'(1);
        rem         = 32'(CHAIN_LEN) - 32'(cnt_q);

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = WAIT_BYTE;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    cnt_d   = '0;
                end
            end
            WAIT_BYTE: begin
                if (s_valid && s_ready_q) begin
                    byte_d      = s_data;
                    nbits_d     = bits_for_byte(rem);
                    k_d         = '0;
                    prog_en_d   = 1'b1;
                    prog_data_d = s_data[0];
                    state_d     = SHIFT;
                end
            end
            SHIFT: begin
                cap_en = 1'b1;
                cnt_d  = cnt_q + CNT_W'(1);
                k_d    = k_next;
                if (k_q == nbits_q - bitcnt_t'(1)) begin
                    commit      = 1'b1;
                    prog_data_d = 1'b0;
                    state_d     = (32'(cnt_q) + 32'd1 == 32'(CHAIN_LEN)) ? FINISH : WAIT_BYTE;
                end else begin
                    prog_en_d   = 1'b1;
                    prog_data_d = byte_q[k_next[IDX_W-1:0]];
                end
            end
            FINISH: begin
                if (slot_free) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Only offer to take a byte when its readback bits are guaranteed a home.
        s_ready_d = (state_d == WAIT_BYTE) && slot_free && !commit;
    end

    always_ff @(posedge prog_clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            k_q         <= '0;
            nbits_q     <= '0;
            byte_q      <= '0;
            prog_en_q   <= 1'b0;
            prog_data_q <= 1'b0;
            s_ready_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            k_q         <= k_d;
            nbits_q     <= nbits_d;
            byte_q      <= byte_d;
            prog_en_q   <= prog_en_d;
            prog_data_q <= prog_data_d;
            s_ready_q   <= s_ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    readback_assembler u_readback (
        .clk_i       (prog_clk),
        .rst_i       (rst),
        .cap_en_i    (cap_en),
        .cap_idx_i   (k_q[IDX_W-1:0]),
        .cap_bit_i   (prog_ret),
        .commit_i    (commit),
        .r_ready_i   (r_ready),
        .r_data_o    (r_data),
        .r_valid_o   (r_valid),
        .slot_free_o (slot_free)
    );

    assign s_ready   = s_ready_q;
    assign prog_en   = prog_en_q;
    assign prog_data = prog_data_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule
